j1_wb_arbiter: RTL and testbench

//  Shares one classic-pipelined Wishbone master port between the J1 instruction bus and data bus.
//  - Accepts level requests from both buses.
//  - Grants one at a time, alternating between them (round-robin).
//  - Runs exactly one Wishbone transaction per grant and returns read data plus a one-cycle ack.
//  - Sits between the J1 core and the Wishbone interconnect.

---
 rtl/j1_wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_j1_wb_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/j1_wb_arbiter.sv
// j1_wb_arbiter: round-robin sharing of one pipelined Wishbone master between the J1 ibus and dbus.
// Optional bus timeout is compiled in when WB_ARB_TIMEOUT_EN is defined.
module j1_wb_arbiter #(
  parameter int unsigned adr_width      = 16,
  parameter int unsigned dat_width      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [adr_width-1:0] i_adr,
  input  logic                 i_re,
  output logic [dat_width-1:0] i_dat,
  output logic                 i_ack,
  input  logic [adr_width-1:0] d_adr,
  input  logic                 d_re,
  input  logic                 d_we,
  input  logic [dat_width-1:0] d_dat_i,
  output logic [dat_width-1:0] d_dat_o,
  output logic                 d_ack,
  output logic [adr_width-1:0] wb_adr,
  output logic                 wb_cyc,
  output logic                 wb_stb,
  output logic                 wb_we,
  output logic [dat_width-1:0] wb_dat_o,
  input  logic [dat_width-1:0] wb_dat_i,
  input  logic                 wb_ack,
  input  logic                 wb_stall,
  output logic                 wb_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state, state_nx;
  logic   gnt_d;  // current/last grant: 1 = dbus, 0 = ibus
  logic   d_req_c, start_c, grant_d_c, to_wait_c, finish_c, tmo_c, tmo_fire_c;

  assign d_req_c = d_re | d_we;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_c = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Cycles spent with the bus owned; restarts on every grant.
  always_ff @(posedge clk) begin
    if (rst || start_c) begin
      tmo_cnt <= '0;
    end else if (state == REQ || state == WAIT) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`else
  logic [31:0] unused_tmo;

  assign unused_tmo = 32'(TIMEOUT_CYCLES);
  assign tmo_c      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and one-cycle control strobes.
  always_comb begin
    state_nx   = state;
    start_c    = 1'b0;
    grant_d_c  = gnt_d;
    to_wait_c  = 1'b0;
    finish_c   = 1'b0;
    tmo_fire_c = 1'b0;
    case (state)
      IDLE: begin
        if (i_re || d_req_c) begin
          start_c   = 1'b1;
          grant_d_c = d_req_c && !(i_re && gnt_d);
          state_nx  = REQ;
        end
      end
      REQ: begin
        // An ack while stalled is a slave protocol violation and is dropped.
        if (!wb_stall && wb_ack) begin
          finish_c = 1'b1;
          state_nx = DONE;
        end else if (tmo_c) begin
          tmo_fire_c = 1'b1;
          state_nx   = DONE;
        end else if (!wb_stall) begin
          to_wait_c = 1'b1;
          state_nx  = WAIT;
        end
      end
      WAIT: begin
        if (wb_ack) begin
          finish_c = 1'b1;
          state_nx = DONE;
        end else if (tmo_c) begin
          tmo_fire_c = 1'b1;
          state_nx   = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered bus outputs, grant memory and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_d    <= 1'b0;
      wb_adr   <= '0;
      wb_cyc   <= 1'b0;
      wb_stb   <= 1'b0;
      wb_we    <= 1'b0;
      wb_dat_o <= '0;
      wb_err   <= 1'b0;
      i_dat    <= '0;
      i_ack    <= 1'b0;
      d_dat_o  <= '0;
      d_ack    <= 1'b0;
    end else begin
      i_ack  <= 1'b0;
      d_ack  <= 1'b0;
      wb_err <= 1'b0;
      if (start_c) begin
        gnt_d  <= grant_d_c;
        wb_adr <= grant_d_c ? d_adr : i_adr;
        wb_we  <= grant_d_c && d_we;
        if (grant_d_c) wb_dat_o <= d_dat_i;
        wb_cyc <= 1'b1;
        wb_stb <= 1'b1;
      end
      if (to_wait_c) wb_stb <= 1'b0;
      if (finish_c || tmo_fire_c) begin
        wb_cyc <= 1'b0;
        wb_stb <= 1'b0;
        i_ack  <= !gnt_d;
        d_ack  <= gnt_d;
        wb_err <= tmo_fire_c;
        if (!gnt_d) begin
          i_dat <= tmo_fire_c ? '1 : wb_dat_i;
        end else if (tmo_fire_c || !wb_we) begin
          d_dat_o <= tmo_fire_c ? '1 : wb_dat_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_j1_wb_arbiter.sv
// Bench for j1_wb_arbiter: directed scenarios plus random two-master traffic against a
// transaction-level model with a randomly stalling memory slave.
module tb_j1_wb_arbiter;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_adr, d_adr, d_dat_i, wb_dat_i;
  logic        i_re, d_re, d_we, wb_ack, wb_stall;
  logic [15:0] i_dat, d_dat_o, wb_adr, wb_dat_o;
  logic        i_ack, d_ack, wb_cyc, wb_stb, wb_we, wb_err;

  always #5 clk = ~clk;

  j1_wb_arbiter #(.adr_width(16), .dat_width(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_adr(i_adr), .i_re(i_re), .i_dat(i_dat), .i_ack(i_ack),
    .d_adr(d_adr), .d_re(d_re), .d_we(d_we), .d_dat_i(d_dat_i), .d_dat_o(d_dat_o), .d_ack(d_ack),
    .wb_adr(wb_adr), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_stall(wb_stall), .wb_err(wb_err)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:65535];

  // Transaction-level model state
  bit          busy, cur_d, last_d, t_we, was_done, auto_req, force_plan, a0, f_a0;
  int          k, s, w, k_ack, f_s, f_w;
  logic [15:0] t_adr, exp_i_dat, exp_d_dat;
  bit          glog[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    busy = 0; last_d = 0; was_done = 0;
    exp_i_dat = '0; exp_d_dat = '0;
    glog.delete();
  endtask

  task automatic set_plan(input int ps, input bit pa0, input int pw);
    force_plan = 1; f_s = ps; f_a0 = pa0; f_w = pw;
  endtask

  // One clock: check outputs against the model, then drive slave and requesters.
  task automatic step();
    bit done_prev, exp_d, exp_cyc, ack_now, dreq, acked_i, acked_d;
    int kind;
    tick();
    done_prev = was_done; was_done = 0; acked_i = 0; acked_d = 0;
    dreq = d_re | d_we;
    if (!busy) begin
      exp_cyc = (i_re | dreq) && !done_prev;
      checks++;
      if (wb_cyc !== exp_cyc) begin
        errors++; $display("FAIL grant_start: wb_cyc=%b required %b", wb_cyc, exp_cyc);
      end
      checks++;
      if (i_ack !== 1'b0 || d_ack !== 1'b0 || wb_err !== 1'b0) begin
        errors++; $display("FAIL idle_quiet: i_ack=%b d_ack=%b wb_err=%b required 0", i_ack, d_ack, wb_err);
      end
      if (exp_cyc) begin
        if (i_re && dreq) exp_d = !last_d;
        else              exp_d = dreq;
        t_adr = exp_d ? d_adr : i_adr;
        t_we  = exp_d && d_we;
        checks++;
        if (wb_stb !== 1'b1 || wb_adr !== t_adr || wb_we !== t_we) begin
          errors++;
          $display("FAIL grant_fields: stb=%b adr=%h we=%b required stb=1 adr=%h we=%b",
                   wb_stb, wb_adr, wb_we, t_adr, t_we);
        end
        if (t_we) begin
          checks++;
          if (wb_dat_o !== d_dat_i) begin
            errors++; $display("FAIL write_data: wb_dat_o=%h required %h", wb_dat_o, d_dat_i);
          end
        end
        last_d = exp_d; cur_d = exp_d; glog.push_back(exp_d); busy = 1; k = 0;
        if (force_plan) begin s = f_s; a0 = f_a0; w = f_w; end
        else begin s = $urandom_range(0, 3); a0 = 1'($urandom_range(0, 1)); w = $urandom_range(0, 2); end
        k_ack = a0 ? s + 1 : s + 2 + w;
      end
    end else begin
      k++;
      ack_now = (k == k_ack);
      checks++;
      if (i_ack !== (ack_now && !cur_d) || d_ack !== (ack_now && cur_d)) begin
        errors++;
        $display("FAIL ack_timing: k=%0d i_ack=%b d_ack=%b required ack at k=%0d to %s",
                 k, i_ack, d_ack, k_ack, cur_d ? "dbus" : "ibus");
      end
      checks++;
      if (wb_cyc !== !ack_now || wb_stb !== (k <= s) || wb_err !== 1'b0) begin
        errors++;
        $display("FAIL bus_phase: k=%0d cyc=%b stb=%b err=%b required cyc=%b stb=%b err=0",
                 k, wb_cyc, wb_stb, wb_err, !ack_now, (k <= s));
      end
      if (!ack_now) begin
        checks++;
        if (wb_adr !== t_adr || wb_we !== t_we) begin
          errors++; $display("FAIL bus_hold: adr=%h we=%b required adr=%h we=%b", wb_adr, wb_we, t_adr, t_we);
        end
      end else begin
        checks++;
        if (i_dat !== exp_i_dat || d_dat_o !== exp_d_dat) begin
          errors++;
          $display("FAIL read_data: i_dat=%h d_dat_o=%h required i_dat=%h d_dat_o=%h",
                   i_dat, d_dat_o, exp_i_dat, exp_d_dat);
        end
        busy = 0; was_done = 1;
        if (cur_d) begin d_re = 0; d_we = 0; acked_d = 1; end
        else begin i_re = 0; acked_i = 1; end
      end
    end
    // Slave: stall s cycles (with stray acks), then ack per the plan.
    wb_ack = 1'b0; wb_stall = 1'($urandom_range(0, 1)); wb_dat_i = 16'($urandom);
    if (busy) begin
      if (k < s) begin
        wb_stall = 1'b1; wb_ack = 1'($urandom_range(0, 1));
      end else begin
        if (k == s) wb_stall = 1'b0;
        if (k == k_ack - 1) begin
          wb_ack = 1'b1;
          if (wb_we) mem[wb_adr] = wb_dat_o;
          else       wb_dat_i = mem[wb_adr];
          if (!cur_d)     exp_i_dat = mem[t_adr];
          else if (!t_we) exp_d_dat = mem[t_adr];
        end
      end
    end
    if (auto_req) begin
      if (!i_re && !acked_i && $urandom_range(0, 2) == 0) begin
        i_re = 1; i_adr = 16'($urandom_range(0, 63));
      end
      if (!d_re && !d_we && !acked_d && $urandom_range(0, 2) == 0) begin
        kind = $urandom_range(0, 2);
        d_re = (kind != 1); d_we = (kind != 0);
        d_adr = 16'($urandom_range(0, 63)); d_dat_i = 16'($urandom);
      end
    end
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n = 0;
    while ((busy || i_re || d_re || d_we) && n < budget) begin
      step();
      n++;
    end
    if (busy || i_re || d_re || d_we) begin
      checks++; errors++; $display("FAIL %s_timeout: still busy after %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1; i_re = 0; d_re = 0; d_we = 0; wb_ack = 0; wb_stall = 0;
    i_adr = '0; d_adr = '0; d_dat_i = '0; wb_dat_i = '0;
    tick(); tick();
    checks++;
    if ({i_ack, d_ack, wb_cyc, wb_stb, wb_we, wb_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ack=%b%b cyc=%b stb=%b we=%b err=%b required all 0",
               i_ack, d_ack, wb_cyc, wb_stb, wb_we, wb_err);
    end
    checks++;
    if (i_dat !== 16'h0 || d_dat_o !== 16'h0 || wb_adr !== 16'h0 || wb_dat_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: i_dat=%h d_dat_o=%h wb_adr=%h wb_dat_o=%h required 0",
               i_dat, d_dat_o, wb_adr, wb_dat_o);
    end
    rst = 0;
    model_reset();
  endtask

  task automatic test_read_latency();
    int  n = 0;
    bit  got = 0;
    test_reset();
    mem[16'h0100] = 16'hBEEF;
    set_plan(0, 0, 0);
    i_re = 1; i_adr = 16'h0100;
    while (!got && n < 20) begin
      step(); n++;
      if (n == 1) begin
        checks++;
        if (wb_adr !== 16'h0100 || wb_we !== 1'b0) begin
          errors++; $display("FAIL t1_bus: wb_adr=%h wb_we=%b required 0100/0", wb_adr, wb_we);
        end
      end
      if (i_ack === 1'b1) got = 1;
    end
    checks++;
    if (!got || n != 3) begin
      errors++; $display("FAIL t1_latency: ack after %0d cycles (seen=%b) required 3", n, got);
    end
    checks++;
    if (i_dat !== 16'hBEEF) begin
      errors++; $display("FAIL t1_data: i_dat=%h required beef", i_dat);
    end
    step();
    checks++;
    if (i_ack !== 1'b0) begin
      errors++; $display("FAIL t1_ack_width: i_ack=%b required 0", i_ack);
    end
  endtask

  task automatic test_tie_break();
    test_reset();
    mem[16'h0200] = 16'h5A5A;
    set_plan(0, 1, 0);
    d_re = 0; d_we = 1; d_adr = 16'h4000; d_dat_i = 16'h1234;
    i_re = 1; i_adr = 16'h0200;
    step();
    checks++;
    if (wb_we !== 1'b1 || wb_adr !== 16'h4000 || wb_dat_o !== 16'h1234) begin
      errors++;
      $display("FAIL t2_first: we=%b adr=%h dat=%h required 1/4000/1234", wb_we, wb_adr, wb_dat_o);
    end
    run_until_idle(40, "t2");
    checks++;
    if (glog.size() != 2 || glog[0] != 1'b1 || glog[1] != 1'b0) begin
      errors++; $display("FAIL t2_order: %0d grants, first=%0d required dbus then ibus", glog.size(),
                         glog.size() > 0 ? int'(glog[0]) : -1);
    end
    checks++;
    if (mem[16'h4000] !== 16'h1234 || i_dat !== 16'h5A5A) begin
      errors++; $display("FAIL t2_data: mem=%h i_dat=%h required 1234/5a5a", mem[16'h4000], i_dat);
    end
  endtask

  task automatic test_stall();
    int stb_n = 0, cyc_n = 0, n = 0;
    test_reset();
    set_plan(3, 0, 2);
    i_re = 1; i_adr = 16'h0033;
    while ((busy || i_re) && n < 40) begin
      step(); n++;
      if (wb_stb === 1'b1) stb_n++;
      if (wb_cyc === 1'b1) cyc_n++;
    end
    checks++;
    if (stb_n != 4 || cyc_n != 7) begin
      errors++; $display("FAIL t3_stall: stb cycles=%0d cyc cycles=%0d required 4/7", stb_n, cyc_n);
    end
  endtask

  task automatic test_ack_no_wait();
    int n = 0;
    bit got = 0;
    test_reset();
    mem[16'h0077] = 16'hC0DE;
    set_plan(1, 1, 0);
    d_re = 1; d_we = 0; d_adr = 16'h0077;
    while (!got && n < 20) begin
      step(); n++;
      if (d_ack === 1'b1) got = 1;
    end
    checks++;
    if (!got || n != 3 || d_dat_o !== 16'hC0DE) begin
      errors++; $display("FAIL t4_no_wait: ack after %0d (seen=%b) d_dat_o=%h required 3/c0de", n, got, d_dat_o);
    end
    run_until_idle(10, "t4");
  endtask

  task automatic test_reset_mid();
    test_reset();
    set_plan(0, 0, 5);
    i_re = 1; i_adr = 16'h0011;
    step(); step();
    checks++;
    if (wb_cyc !== 1'b1 || wb_stb !== 1'b0) begin
      errors++; $display("FAIL t5_wait: cyc=%b stb=%b required 1/0", wb_cyc, wb_stb);
    end
    rst = 1; wb_ack = 0;
    tick();
    checks++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
      errors++; $display("FAIL t5_reset: cyc=%b stb=%b ack=%b%b required 0", wb_cyc, wb_stb, i_ack, d_ack);
    end
    rst = 0; i_re = 0; wb_ack = 1; wb_stall = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      wb_ack = 0;
      checks++;
      if (wb_cyc !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
        errors++; $display("FAIL t5_late_ack: cyc=%b ack=%b%b required 0", wb_cyc, i_ack, d_ack);
      end
    end
    model_reset();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc_n = 0;
    bit got = 0;
    test_reset();
    d_re = 1; d_we = 0; d_adr = 16'h0042; wb_ack = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      wb_stall = 1'($urandom_range(0, 1));
      tick();
      if (d_ack === 1'b1) got = 1;
      else if (wb_cyc === 1'b1) cyc_n++;
    end
    checks++;
    if (!got || cyc_n != TMO || d_dat_o !== 16'hFFFF || wb_err !== 1'b1 || wb_cyc !== 1'b0) begin
      errors++;
      $display("FAIL t6_timeout: ack=%b cyc cycles=%0d d_dat_o=%h err=%b cyc=%b required 1/%0d/ffff/1/0",
               got, cyc_n, d_dat_o, wb_err, wb_cyc, TMO);
    end
    d_re = 0;
    tick();
    checks++;
    if (d_ack !== 1'b0 || wb_err !== 1'b0) begin
      errors++; $display("FAIL t6_pulse: d_ack=%b wb_err=%b required 0", d_ack, wb_err);
    end
    model_reset();
  endtask
`endif

  task automatic test_random();
    int n_d = 0;
    test_reset();
    force_plan = 0; auto_req = 1;
    repeat (2000) step();
    auto_req = 0;
    run_until_idle(60, "random");
    foreach (glog[i]) if (glog[i]) n_d++;
    checks++;
    if (n_d == 0 || n_d == glog.size()) begin
      errors++; $display("FAIL random_mix: dbus grants=%0d of %0d required both masters", n_d, glog.size());
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5C3;
    force_plan = 0; auto_req = 0;
    test_reset();
    test_read_latency();
    test_tie_break();
    test_stall();
    test_ack_no_wait();
    test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
